// File: rtl/adventure_game_move_input_if.sv
// Player input bundle between the raw button/game-core side and the move front end.
//   btn_n/s/e/w/start : raw asynchronous push-buttons, active-high
//   game_over         : level from the game core result output
//   start             : one-cycle start command
//   direction         : last accepted move code (N=00 S=01 E=10 W=11)
//   move_valid        : one-cycle pulse, direction carries a new move
//   conflict          : one-cycle pulse, press rejected (several directions held)
interface adventure_game_move_input_if;
   logic       btn_n;
   logic       btn_s;
   logic       btn_e;
   logic       btn_w;
   logic       btn_start;
   logic       game_over;
   logic       start;
   logic [1:0] direction;
   logic       move_valid;
   logic       conflict;

   // Driver of buttons / consumer of commands
   modport master (
      output btn_n, btn_s, btn_e, btn_w, btn_start, game_over,
      input  start, direction, move_valid, conflict
   );

   // The move front end itself
   modport slave (
      input  btn_n, btn_s, btn_e, btn_w, btn_start, game_over,
      output start, direction, move_valid, conflict
   );
endinterface

// File: rtl/adventure_game_move_input.sv
// Move front end: synchronises, debounces and edge-detects the player buttons and
// turns them into clean single-cycle start / move_valid / conflict commands.
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : button inputs, game_over feedback and command outputs (slave side)
module adventure_game_move_input #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned CNT_W           = 20
) (
   input  logic                         clk,
   input  logic                         reset,
   adventure_game_move_input_if.slave   bus
);

   localparam int unsigned NUM_BTN   = 5;
   localparam int unsigned BTN_START = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PLAY    = 2'd1,
      RELEASE = 2'd2,
      DONE    = 2'd3
   } state_t;

   logic [NUM_BTN-1:0]            raw;
   logic [NUM_BTN-1:0]            sync1_q, sync2_q;
   logic [NUM_BTN-1:0]            deb_q, deb_d;
   logic [NUM_BTN-1:0]            deb_dly_q;
   logic [NUM_BTN-1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic [NUM_BTN-1:0]            rise;
   logic [3:0]                    dir_lvl, dir_rise;

   state_t     state_q, state_d;
   logic       start_q, start_d;
   logic       move_valid_q, move_valid_d;
   logic       conflict_q, conflict_d;
   logic [1:0] direction_q, direction_d;

   // Index order doubles as the direction code: N=0 S=1 E=2 W=3
   assign raw = {bus.btn_start, bus.btn_w, bus.btn_e, bus.btn_s, bus.btn_n};

   // Per-button debounce: level follows the synced input only after a full stable run
   always_comb begin
      deb_d = deb_q;
      cnt_d = cnt_q;
      for (int i = 0; i < NUM_BTN; i++) begin
         if (sync2_q[i] != deb_q[i]) begin
            if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
               deb_d[i] = sync2_q[i];
               cnt_d[i] = '0;
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end else begin
            cnt_d[i] = '0;
         end
      end
   end

   assign rise     = deb_q & ~deb_dly_q;
   assign dir_lvl  = deb_q[3:0];
   assign dir_rise = rise[3:0];

   // Command FSM; start has priority and swallows same-cycle direction edges
   always_comb begin
      state_d      = state_q;
      start_d      = 1'b0;
      move_valid_d = 1'b0;
      conflict_d   = 1'b0;
      direction_d  = direction_q;
      if (rise[BTN_START]) begin
         start_d = 1'b1;
         state_d = PLAY;
      end else begin
         case (state_q)
            PLAY: begin
               if (bus.game_over) begin
                  state_d = DONE;
               end else if (dir_rise != 4'b0000) begin
                  state_d = RELEASE;
                  case (dir_lvl)
                     4'b0001: begin direction_d = 2'd0; move_valid_d = 1'b1; end
                     4'b0010: begin direction_d = 2'd1; move_valid_d = 1'b1; end
                     4'b0100: begin direction_d = 2'd2; move_valid_d = 1'b1; end
                     4'b1000: begin direction_d = 2'd3; move_valid_d = 1'b1; end
                     default: conflict_d = 1'b1;
                  endcase
               end
            end
            RELEASE: begin
               if (bus.game_over) begin
                  state_d = DONE;
               end else if (dir_lvl == 4'b0000) begin
                  state_d = PLAY;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q      <= '0;
         sync2_q      <= '0;
         deb_q        <= '0;
         deb_dly_q    <= '0;
         cnt_q        <= '0;
         state_q      <= IDLE;
         start_q      <= 1'b0;
         move_valid_q <= 1'b0;
         conflict_q   <= 1'b0;
         direction_q  <= 2'd0;
      end else begin
         sync1_q      <= raw;
         sync2_q      <= sync1_q;
         deb_q        <= deb_d;
         deb_dly_q    <= deb_q;
         cnt_q        <= cnt_d;
         state_q      <= state_d;
         start_q      <= start_d;
         move_valid_q <= move_valid_d;
         conflict_q   <= conflict_d;
         direction_q  <= direction_d;
      end
   end

   assign bus.start      = start_q;
   assign bus.move_valid = move_valid_q;
   assign bus.conflict   = conflict_q;
   assign bus.direction  = direction_q;

endmodule

// File: tb/tb_adventure_game_move_input.sv
// Bench for adventure_game_move_input: directed button sequences push expected
// command events into a queue; a negedge monitor pops and compares each pulse.
module tb_adventure_game_move_input;

   localparam int LAT = 7;   // raw rise -> pulse, DEBOUNCE_CYCLES=4

   typedef struct {
      int         kind;      // 0 start, 1 move, 2 conflict
      logic [1:0] dir;
      int         cyc;
   } ev_t;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   n_pass = 0;
   int   n_total = 0;
   ev_t  exp_q[$];

   adventure_game_move_input_if bus();

   adventure_game_move_input #(.DEBOUNCE_CYCLES(4), .CNT_W(20)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input bit ok, input string detail);
      n_total++;
      if (ok) n_pass++;
      else $display("FAIL %s: %s", name, detail);
   endtask

   task automatic set_btns(input logic [4:0] m);
      bus.btn_n     = m[0];
      bus.btn_s     = m[1];
      bus.btn_e     = m[2];
      bus.btn_w     = m[3];
      bus.btn_start = m[4];
   endtask

   // Hold mask for n cycles, optionally expecting one event LAT cycles after the rise
   task automatic press(input logic [4:0] m, input int n, input bit expect_ev,
                        input int kind, input logic [1:0] d);
      ev_t e;
      @(negedge clk);
      set_btns(m);
      if (expect_ev) begin
         e.kind = kind;
         e.dir  = d;
         e.cyc  = cyc + LAT;
         exp_q.push_back(e);
      end
      repeat (n) @(negedge clk);
      set_btns(5'b0);
      repeat (20) @(negedge clk);
   endtask

   task automatic chk_idle_outputs(input string name, input logic [1:0] d);
      chk({name, "_start"}, bus.start == 1'b0, $sformatf("got %0b want 0", bus.start));
      chk({name, "_move_valid"}, bus.move_valid == 1'b0, $sformatf("got %0b want 0", bus.move_valid));
      chk({name, "_conflict"}, bus.conflict == 1'b0, $sformatf("got %0b want 0", bus.conflict));
      chk({name, "_direction"}, bus.direction == d, $sformatf("got %0b want %0b", bus.direction, d));
   endtask

   // Monitor: every asserted command pulse must match the next expected event
   always @(negedge clk) begin
      int  n_hi;
      int  kind;
      ev_t e;
      if (!reset && (bus.start || bus.move_valid || bus.conflict)) begin
         n_hi = int'(bus.start) + int'(bus.move_valid) + int'(bus.conflict);
         kind = bus.start ? 0 : (bus.move_valid ? 1 : 2);
         if (exp_q.size() == 0) begin
            chk("unexpected_pulse", 1'b0,
                $sformatf("got kind %0d dir %0b at cycle %0d, want no pulse", kind, bus.direction, cyc));
         end else begin
            e = exp_q.pop_front();
            chk("event", n_hi == 1 && kind == e.kind && cyc == e.cyc &&
                         (kind == 0 || bus.direction == e.dir),
                $sformatf("got kind %0d dir %0b cyc %0d pulses %0d, want kind %0d dir %0b cyc %0d pulses 1",
                          kind, bus.direction, cyc, n_hi, e.kind, e.dir, e.cyc));
         end
      end
   end

   initial begin
      set_btns(5'b0);
      bus.game_over = 1'b0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk_idle_outputs("reset", 2'b00);
      reset = 1'b0;
      repeat (5) @(negedge clk);

      // Directions ignored in IDLE
      press(5'b00100, 10, 1'b0, 0, 2'b00);
      // Start press -> single start pulse, FSM to PLAY
      press(5'b10000, 10, 1'b1, 0, 2'b00);
      // East held 60 cycles -> exactly one move
      press(5'b00100, 60, 1'b1, 1, 2'b10);
      chk("dir_after_east", bus.direction == 2'b10, $sformatf("got %0b want 10", bus.direction));
      // 3-cycle glitch rejected, 6-cycle press accepted
      press(5'b00001, 3, 1'b0, 0, 2'b00);
      press(5'b00001, 6, 1'b1, 1, 2'b00);
      // Exactly DEBOUNCE_CYCLES long press is accepted
      press(5'b00100, 4, 1'b1, 1, 2'b10);
      // South+west together -> conflict, direction kept
      press(5'b01010, 10, 1'b1, 2, 2'b10);
      chk("dir_after_conflict", bus.direction == 2'b10, $sformatf("got %0b want 10", bus.direction));

      // Game over: moves ignored until a new start
      @(negedge clk);
      bus.game_over = 1'b1;
      repeat (3) @(negedge clk);
      press(5'b01000, 10, 1'b0, 0, 2'b00);
      bus.game_over = 1'b0;
      repeat (2) @(negedge clk);
      press(5'b10000, 10, 1'b1, 0, 2'b00);
      press(5'b01000, 10, 1'b1, 1, 2'b11);
      chk("dir_after_west", bus.direction == 2'b11, $sformatf("got %0b want 11", bus.direction));

      // Reset mid-debounce with east held through reset
      @(negedge clk);
      set_btns(5'b00100);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      chk_idle_outputs("midreset", 2'b00);
      reset = 1'b0;
      repeat (30) @(negedge clk);
      // Start while east still held: no move since east level already settled
      @(negedge clk);
      bus.btn_start = 1'b1;
      begin
         ev_t e;
         e.kind = 0; e.dir = 2'b00; e.cyc = cyc + LAT;
         exp_q.push_back(e);
      end
      repeat (10) @(negedge clk);
      bus.btn_start = 1'b0;
      repeat (20) @(negedge clk);
      set_btns(5'b0);
      repeat (20) @(negedge clk);
      chk("dir_final", bus.direction == 2'b00, $sformatf("got %0b want 00", bus.direction));

      chk("pending_events", exp_q.size() == 0,
          $sformatf("got %0d outstanding events, want 0", exp_q.size()));
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout at cycle %0d, want normal end", cyc);
      $fatal(1, "timeout");
   end

endmodule
